hs_rx_fifo: RTL and testbench

//  Downstream consumer of the 4-phase bundled-data mux channel (r/a/d). Synchronises r_i into
//  clk, captures d_i, returns a_i, and buffers words in a DEPTH-entry FIFO. Words leave on a

---
 rtl/hs_pkg.sv | 13 +
 rtl/hs_sync.sv | 25 ++
 rtl/hs_rx_fifo.sv | 119 +++++++++++
 tb/tb_hs_rx_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and constants for the 4-phase bundled-data receive bridges.
// HS_RX_SYNC3_EN selects a 3-flop request synchroniser instead of 2.
package hs_pkg;

    typedef enum logic {HS_IDLE, HS_ACK} hs_state_t;

`ifdef HS_RX_SYNC3_EN
    localparam int HS_SYNC_STAGES = 3;
`else
    localparam int HS_SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/hs_sync.sv
// Purpose: S-flop reset-to-0 synchroniser for a single asynchronous level.
// Latency: S clk edges from input change to q.
// Backpressure: none; free-running.
module hs_sync #(
    parameter int S = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [S-1:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[S-2:0], d};
        end
    end

    assign q = r_chain[S-1];

endmodule

// File: rtl/hs_rx_fifo.sv
// Purpose: 4-phase r/a/d receiver into a DEPTH-entry show-ahead FIFO with a valid/ready output.
// Latency: r_i sampled at edge k -> push and a_i=1 after edge k+S (S=2, or 3 with HS_RX_SYNC3_EN).
// Backpressure: when full, a_i is withheld so upstream stalls; output pops on v_o & rdy_i.
module hs_rx_fifo
    import hs_pkg::*;
#(
    parameter int N     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     r_i,
    output logic                     a_i,
    input  logic [N-1:0]             d_i,
    output logic                     v_o,
    input  logic                     rdy_i,
    output logic [N-1:0]             d_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_ack;
    hs_state_t     r_state;

    logic          w_rs;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_ack_nxt;
    hs_state_t     w_state_nxt;

    hs_sync #(.S(HS_SYNC_STAGES)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (r_i),
        .q   (w_rs)
    );

    assign w_full = (r_cnt == CW'(DEPTH));
    assign w_pop  = (r_cnt != '0) && rdy_i;

    // Push is tied to the IDLE->ACK transition, so d_i is sampled exactly once per request.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_push      = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (w_rs && !w_full) begin
                    w_push      = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = HS_ACK;
                end
            end
            HS_ACK: begin
                if (!w_rs) begin
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = HS_IDLE;
                end
            end
            default: begin
                w_ack_nxt   = 1'b0;
                w_state_nxt = HS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HS_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= d_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign a_i   = r_ack;
    assign v_o   = (r_cnt != '0);
    assign d_o   = r_mem[r_rptr];
    assign cnt_o = r_cnt;

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Directed bench for hs_rx_fifo (N=8, DEPTH=4); honours HS_RX_SYNC3_EN for the sync depth.
module tb_hs_rx_fifo;

`ifdef HS_RX_SYNC3_EN
    localparam int S = 3;
`else
    localparam int S = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r_i = 1'b0;
    logic       a_i;
    logic [7:0] d_i = 8'h00;
    logic       v_o;
    logic       rdy_i = 1'b0;
    logic [7:0] d_o;
    logic [2:0] cnt_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         popped;
    int         max_cnt;
    logic       prod_done;

    hs_rx_fifo #(.N(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .r_i   (r_i),
        .a_i   (a_i),
        .d_i   (d_i),
        .v_o   (v_o),
        .rdy_i (rdy_i),
        .d_o   (d_o),
        .cnt_o (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hs_send(input logic [7:0] d);
        int n;
        d_i = d;
        r_i = 1'b1;
        n = 0;
        while (!a_i && n < 40) begin
            tick();
            n++;
        end
        chk("hs_ack_rise", a_i, 1);
        r_i = 1'b0;
        n = 0;
        while (a_i && n < 40) begin
            tick();
            n++;
        end
        chk("hs_ack_fall", a_i, 0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_a", a_i, 0);
        chk("rst_v", v_o, 0);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_d", d_o, 0);
        tick();
        rst = 1'b1;
        tick();

        // T1: single handshake with cycle-exact edges
        d_i = 8'hA5; r_i = 1'b1; rdy_i = 1'b1;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t1_a_lo", a_i, 0);
            chk("t1_v_lo", v_o, 0);
        end
        tick();
        chk("t1_a_hi", a_i, 1);
        chk("t1_v_hi", v_o, 1);
        chk("t1_d", d_o, 8'hA5);
        chk("t1_cnt1", cnt_o, 1);
        r_i = 1'b0;
        tick();
        chk("t1_v_pop", v_o, 0);
        chk("t1_cnt0", cnt_o, 0);
        chk("t1_a_hold", a_i, 1);
        for (int i = 0; i < S - 1; i++) begin
            tick();
            chk("t1_a_hold2", a_i, 1);
        end
        tick();
        chk("t1_a_fall", a_i, 0);
        tick();

        // T2: fill to full, 5th request stalls until a pop frees a slot
        rdy_i = 1'b0;
        for (int w = 1; w <= 4; w++) hs_send(8'(w));
        chk("t2_full", cnt_o, 4);
        d_i = 8'h05; r_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t2_stall_a", a_i, 0);
        chk("t2_stall_cnt", cnt_o, 4);
        chk("t2_head01", d_o, 8'h01);
        rdy_i = 1'b1;
        tick();
        chk("t2_head02", d_o, 8'h02);
        chk("t2_cnt3", cnt_o, 3);
        chk("t2_a_still0", a_i, 0);
        tick();
        chk("t2_a_push", a_i, 1);
        chk("t2_cnt3b", cnt_o, 3);
        chk("t2_head03", d_o, 8'h03);
        r_i = 1'b0;
        tick();
        chk("t2_head04", d_o, 8'h04);
        tick();
        chk("t2_head05", d_o, 8'h05);
        chk("t2_v05", v_o, 1);
        tick();
        chk("t2_empty", v_o, 0);
        for (int i = 0; i < S + 2; i++) tick();
        chk("t2_a_fall", a_i, 0);

        // T3: 64 random words, consumer ready toggling every cycle
        popped = 0; max_cnt = 0; prod_done = 1'b0; rdy_i = 1'b0;
        fork
            begin
                for (int w = 0; w < 64; w++) begin
                    logic [7:0] x;
                    x = 8'($urandom_range(0, 255));
                    exp_q.push_back(x);
                    hs_send(x);
                end
                prod_done = 1'b1;
            end
            begin
                int budget;
                budget = 0;
                while (popped < 64 && budget < 5000) begin
                    tick();
                    budget++;
                    rdy_i = ~rdy_i;
                    if (int'(cnt_o) > max_cnt) max_cnt = int'(cnt_o);
                    if (v_o && rdy_i) begin
                        if (exp_q.size() == 0) chk("t3_underflow", 1, 0);
                        else chk("t3_order", d_o, exp_q.pop_front());
                        popped++;
                    end
                end
            end
        join
        chk("t3_popped", popped, 64);
        chk("t3_cnt_bound", (max_cnt <= 4), 1);
        tick();
        rdy_i = 1'b0;
        tick();
        chk("t3_drained", cnt_o, 0);

        // T4: push and pop on the same edge at cnt=2
        hs_send(8'h11);
        hs_send(8'h22);
        d_i = 8'h33; r_i = 1'b1;
        for (int i = 0; i < S; i++) tick();
        chk("t4_pre_cnt", cnt_o, 2);
        chk("t4_pre_a", a_i, 0);
        rdy_i = 1'b1;
        tick();
        rdy_i = 1'b0;
        chk("t4_cnt", cnt_o, 2);
        chk("t4_a", a_i, 1);
        chk("t4_head22", d_o, 8'h22);
        r_i = 1'b0;
        for (int i = 0; i < S + 1; i++) tick();
        rdy_i = 1'b1;
        tick();
        chk("t4_head33", d_o, 8'h33);
        tick();
        chk("t4_empty", v_o, 0);
        rdy_i = 1'b0;

        // T5: async reset mid-handshake, request still high at release
        hs_send(8'h44);
        hs_send(8'h55);
        d_i = 8'h77; r_i = 1'b1;
        for (int i = 0; i < S + 1; i++) tick();
        chk("t5_pre_a", a_i, 1);
        chk("t5_pre_cnt", cnt_o, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_a", a_i, 0);
        chk("t5_rst_v", v_o, 0);
        chk("t5_rst_cnt", cnt_o, 0);
        d_i = 8'h88;
        tick();
        rst = 1'b1;
        for (int i = 0; i < S; i++) begin
            tick();
            chk("t5_a_lo", a_i, 0);
        end
        tick();
        chk("t5_a_hi", a_i, 1);
        chk("t5_cnt1", cnt_o, 1);
        chk("t5_d88", d_o, 8'h88);
        r_i = 1'b0;
        for (int i = 0; i < S + 4; i++) tick();
        chk("t5_a_fall", a_i, 0);
        chk("t5_one_cap", cnt_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
